// File: rtl/gigatron_video_capture.sv
`default_nettype none
// gigatron_video_capture: rebuilds frames from the Gigatron OUT register and streams visible pixels
// through a small FIFO. Rev 1.0 - initial release.
module gigatron_video_capture #(
  parameter int H_START    = 12,
  parameter int H_VISIBLE  = 160,
  parameter int V_START    = 33,
  parameter int V_VISIBLE  = 480,
  parameter int FIFO_DEPTH = 4,
  parameter int SYNC_TMO   = 400
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_ce,
  input  logic [7:0] i_out,
  output logic       o_px_valid,
  input  logic       i_px_ready,
  output logic [5:0] o_px_data,
  output logic [7:0] o_px_x,
  output logic [8:0] o_px_y,
  output logic       o_px_sof,
  output logic       o_lock,
  output logic       o_frame_done,
  output logic       o_overflow
);

  localparam int                  c_addr_w  = $clog2(FIFO_DEPTH);
  localparam int                  c_tmo_w   = $clog2(SYNC_TMO + 1);
  localparam logic [7:0]          c_h_lo    = 8'(H_START);
  localparam logic [7:0]          c_h_hi    = 8'(H_START + H_VISIBLE);
  localparam logic [9:0]          c_v_lo    = 10'(V_START);
  localparam logic [9:0]          c_v_hi    = 10'(V_START + V_VISIBLE);
  localparam logic [c_tmo_w-1:0]  c_tmo_max = c_tmo_w'(SYNC_TMO);
  localparam logic [c_addr_w:0]   c_depth   = (c_addr_w + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  typedef struct packed {
    logic [5:0] data;
    logic [7:0] x;
    logic [8:0] y;
    logic       sof;
  } px_t;

  state_t              r_state;
  logic                r_prev_v;
  logic                r_prev_h;
  logic [7:0]          r_hcnt;
  logic [9:0]          r_vcnt;
  logic [c_tmo_w-1:0]  r_tmo;
  logic                r_frame_done;
  logic                r_overflow;
  px_t                 r_mem [FIFO_DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_addr_w:0]   r_count;

  logic       w_vfall, w_vrise, w_hfall, w_hrise;
  logic       w_active, w_timeout, w_in_h, w_in_v;
  logic       w_push, w_pop, w_full, w_wr, w_drop;
  logic [7:0] w_x;
  logic [8:0] w_y;
  px_t        w_entry;

  // Edges compare this CE sample against the sync bits held from the previous CE sample.
  assign w_vfall  = i_ce &  r_prev_v & ~i_out[7];
  assign w_vrise  = i_ce & ~r_prev_v &  i_out[7];
  assign w_hfall  = i_ce &  r_prev_h & ~i_out[6];
  assign w_hrise  = i_ce & ~r_prev_h &  i_out[6];

  assign w_active  = (r_state == S_ACTIVE);
  assign w_timeout = w_active & i_ce & ~w_hfall & (r_tmo == c_tmo_max - 1'b1);

  assign w_in_h  = (r_hcnt >= c_h_lo) && (r_hcnt < c_h_hi);
  assign w_in_v  = (r_vcnt >= c_v_lo) && (r_vcnt < c_v_hi);
  assign w_x     = r_hcnt - c_h_lo;
  assign w_y     = 9'(r_vcnt - c_v_lo);
  assign w_entry = {i_out[5:0], w_x, w_y, (w_x == 8'd0) && (w_y == 9'd0)};

  assign w_push = w_active & i_ce & (i_out[7:6] == 2'b11) & w_in_h & w_in_v & ~w_timeout;
  assign w_pop  = o_px_valid & i_px_ready;
  assign w_full = (r_count == c_depth);
  assign w_wr   = w_push & (~w_full | w_pop);
  assign w_drop = w_push & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_prev_v     <= 1'b1;
      r_prev_h     <= 1'b1;
      r_hcnt       <= 8'hFF;
      r_vcnt       <= 10'h3FF;
      r_tmo        <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_frame_done <= w_vfall & w_active;
      if (i_ce) begin
        r_prev_v <= i_out[7];
        r_prev_h <= i_out[6];
        if (w_hrise)                r_hcnt <= '0;
        else if (r_hcnt != 8'hFF)   r_hcnt <= r_hcnt + 8'd1;
        if (w_vrise)                r_vcnt <= '0;
        else if (w_hfall && (r_vcnt != 10'h3FF)) r_vcnt <= r_vcnt + 10'd1;
        if (w_hfall)                r_tmo <= '0;
        else if (r_tmo != c_tmo_max) r_tmo <= r_tmo + 1'b1;
      end
      case (r_state)
        S_IDLE:   if (w_vfall)   r_state <= S_ACTIVE;
        S_ACTIVE: if (w_timeout) r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
      if (w_drop)                   r_overflow <= 1'b1;
      else if (w_vfall && w_active) r_overflow <= 1'b0;
    end
  end

  // Losing lock discards whatever is still queued so stale pixels never follow a relock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_timeout) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_px_valid   = (r_count != '0);
  assign {o_px_data, o_px_x, o_px_y, o_px_sof} = r_mem[r_rd_ptr];
  assign o_lock       = w_active;
  assign o_frame_done = r_frame_done;
  assign o_overflow   = r_overflow;

endmodule
`default_nettype wire
